dm_ram_ctrl: RTL

Data-memory slave sitting directly downstream of the datapath data-memory interface. It consumes the o_DM_* request bundle and produces i_DM_data_ready and i_DM_ReadData.
- Single-port synchronous word-organised RAM.
- Fixed, parameterised access latency.
- Byte-lane write masking per f3.
- Read data returned right-aligned; sign/zero extension is done upstream.

---
 rtl/dm_ram_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/dm_ram_ctrl.sv
// Data-memory slave: single-port word RAM behind a fixed-latency request FSM.
// Byte/half stores are lane-masked; loads return the selected lane right-aligned.
module dm_ram_ctrl #(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [XLEN-1:0] i_DM_Wd,
    input  logic [XLEN-1:0] i_DM_Addr,
    input  logic [2:0]      i_DM_f3,
    input  logic            i_DM_Wen,
    input  logic            i_DM_MemRead,
    output logic            o_DM_data_ready,
    output logic [XLEN-1:0] o_DM_ReadData
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_next;

    logic [AW+1:0]   r_addr;
    logic [XLEN-1:0] r_wd;
    logic [1:0]      r_f3;
    logic            r_is_store;

    logic [XLEN-1:0] r_mem [DEPTH_WORDS];
    logic            r_ready;
    logic [XLEN-1:0] r_rdata;

    logic            w_accept;
    logic            w_commit;
    logic [AW+1:0]   w_op_addr;
    logic [XLEN-1:0] w_op_wd;
    logic [1:0]      w_op_f3;
    logic            w_op_store;
    logic [AW-1:0]   w_word_idx;
    logic [3:0]      w_be;
    logic [XLEN-1:0] w_wdata;
    logic [XLEN-1:0] w_rword;
    logic [XLEN-1:0] w_load_data;
    logic            w_unused;

    assign w_accept = (r_state == S_IDLE) && (i_DM_Wen || i_DM_MemRead);
    assign w_unused = ^{i_DM_Addr[XLEN-1:AW+2], i_DM_f3[2]};

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = (LATENCY == 1) ? S_RESP : S_WAIT;
                    w_cnt_next   = CW'(LATENCY - 1);
                end
            end
            S_WAIT: begin
                if (r_cnt == CW'(1)) begin
                    w_next_state = S_RESP;
                end
                w_cnt_next = r_cnt - CW'(1);
            end
            S_RESP:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // With LATENCY==1 the commit edge is the accept edge, so the live inputs are used.
    always_comb begin
        w_op_addr  = (r_state == S_IDLE) ? i_DM_Addr[AW+1:0] : r_addr;
        w_op_wd    = (r_state == S_IDLE) ? i_DM_Wd           : r_wd;
        w_op_f3    = (r_state == S_IDLE) ? i_DM_f3[1:0]      : r_f3;
        w_op_store = (r_state == S_IDLE) ? i_DM_Wen          : r_is_store;
        w_commit   = (w_next_state == S_RESP);
        w_word_idx = w_op_addr[AW+1:2];
        w_rword    = r_mem[w_word_idx];
        case (w_op_f3)
            2'b00: begin
                w_be        = 4'b0001 << w_op_addr[1:0];
                w_wdata     = {4{w_op_wd[7:0]}};
                w_load_data = XLEN'(w_rword[{w_op_addr[1:0], 3'b000} +: 8]);
            end
            2'b01: begin
                w_be        = w_op_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata     = {2{w_op_wd[15:0]}};
                w_load_data = XLEN'(w_rword[{w_op_addr[1], 4'b0000} +: 16]);
            end
            default: begin
                w_be        = 4'b1111;
                w_wdata     = w_op_wd;
                w_load_data = w_rword;
            end
        endcase
    end

    // Registered outputs
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_ready <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ready <= w_commit;
            if (w_commit && !w_op_store) begin
                r_rdata <= w_load_data;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_addr     <= i_DM_Addr[AW+1:0];
            r_wd       <= i_DM_Wd;
            r_f3       <= i_DM_f3[1:0];
            r_is_store <= i_DM_Wen;
        end
    end

    // NOTE: RAM has no reset branch so it maps onto block RAM; only the write is gated by i_rst.
    always_ff @(posedge i_clk) begin
        if (i_rst && w_commit && w_op_store) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_word_idx][8*b +: 8] <= w_wdata[8*b +: 8];
                end
            end
        end
    end

    assign o_DM_data_ready = r_ready;
    assign o_DM_ReadData   = r_rdata;

endmodule
